// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the next-PC stage
// Holds the next-PC source select, the sequential increment and the default
// reset/exception vectors used as parameter defaults by pc_next_unit.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BR,
        PC_J,
        PC_JR,
        PC_EXC
    } pc_sel_e;

    localparam int          PC_INCR          = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_next_unit_if.sv
// rtl/pc_next_unit_if.sv - control and status bundle of the next-PC stage
// slave modport (pc_next_unit): takes en, branch/jump/jr/link/ret/exception
// controls and their operands; drives pc, pc_plus4, ras_top, ras_valid,
// ras_overflow and misaligned. master modport is the mirror for the driver.
interface pc_next_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  en;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_offset;
    logic                  jump;
    logic [25:0]           jump_index;
    logic                  jump_reg;
    logic [ADDR_WIDTH-1:0] jr_target;
    logic                  link;
    logic                  ret;
    logic                  exception;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic                  ras_valid;
    logic                  ras_overflow;
    logic                  misaligned;

    modport master (
        output en, branch_taken, branch_offset, jump, jump_index,
               jump_reg, jr_target, link, ret, exception,
        input  pc, pc_plus4, ras_top, ras_valid, ras_overflow, misaligned
    );

    modport slave (
        input  en, branch_taken, branch_offset, jump, jump_index,
               jump_reg, jr_target, link, ret, exception,
        output pc, pc_plus4, ras_top, ras_valid, ras_overflow, misaligned
    );
endinterface

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return-address stack for jr $ra prediction
// Ports: clk, rst (async, active high); push/pop strobes already qualified by
// the caller; din is the return address to push; top is the newest entry
// (0 when empty); valid = non-empty; overflow is sticky once a push has
// discarded the oldest entry.
module return_addr_stack #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  valid,
    output logic                  overflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_m1;
    logic [CNT_W-1:0]      count;
    logic                  empty;

    assign ptr_m1 = ptr - PTR_W'(1);
    assign empty  = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && pop && !empty) begin
            // Call-through-return: replace the top in place.
            entries[ptr_m1] <= din;
        end else if (push) begin
            // When full the pointer sits on the oldest entry, so the write
            // below overwrites it and the count saturates.
            entries[ptr] <= din;
            ptr          <= ptr + PTR_W'(1);
            if (count == FULL) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr_m1;
            count <= count - CNT_W'(1);
        end
    end

    assign top   = empty ? '0 : entries[ptr_m1];
    assign valid = !empty;
endmodule

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - PC register with prioritised next-PC select and RAS
// Ports: clk, rst (async, active high); bus (pc_next_unit_if.slave) carries
// the stall enable, branch/jump/jr/exception controls with their operands,
// link/ret RAS hints, and returns pc, pc_plus4, ras_top, ras_valid,
// ras_overflow and the combinational misaligned-JR flag.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_next_unit_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] EXC_PC = ADDR_WIDTH'(EXC_VECTOR);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] br_target;
    logic [ADDR_WIDTH-1:0] j_target;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  misaligned;
    logic                  ras_upd;
    logic                  ras_push;
    logic                  ras_pop;
    pc_sel_e               sel;

    assign pc_plus4  = pc_q + ADDR_WIDTH'(PC_INCR);
    assign br_target = pc_plus4 + (bus.branch_offset << 2);

    // J keeps the region bits above the 28-bit pseudo-direct field.
    generate
        if (ADDR_WIDTH > 28) begin : g_j_region
            assign j_target = {pc_plus4[ADDR_WIDTH-1:28], bus.jump_index, 2'b00};
        end else begin : g_j_flat
            assign j_target = {bus.jump_index, 2'b00};
        end
    endgenerate

    // Only a JR that actually wins the priority can trap.
    assign misaligned = !bus.exception && bus.jump_reg && (bus.jr_target[1:0] != 2'b00);

    always_comb begin
        sel = PC_SEQ;
        if (bus.exception || misaligned) begin
            sel = PC_EXC;
        end else if (bus.jump_reg) begin
            sel = PC_JR;
        end else if (bus.jump) begin
            sel = PC_J;
        end else if (bus.branch_taken) begin
            sel = PC_BR;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            PC_BR:   next_pc = br_target;
            PC_J:    next_pc = j_target;
            PC_JR:   next_pc = bus.jr_target;
            PC_EXC:  next_pc = EXC_PC;
            default: next_pc = pc_plus4;
        endcase
    end

    // An exception redirects even while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RST_PC;
        end else if (bus.exception) begin
            pc_q <= EXC_PC;
        end else if (bus.en) begin
            pc_q <= next_pc;
        end
    end

    assign ras_upd  = bus.en && !bus.exception && !misaligned;
    assign ras_push = ras_upd && bus.link && (bus.jump || bus.jump_reg);
    assign ras_pop  = ras_upd && bus.jump_reg && bus.ret;

    return_addr_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .din      (pc_plus4),
        .top      (bus.ras_top),
        .valid    (bus.ras_valid),
        .overflow (bus.ras_overflow)
    );

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.misaligned = misaligned;
endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed self-checking bench for pc_next_unit
module tb_pc_next_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_next_unit_if #(.ADDR_WIDTH(32)) b ();

    pc_next_unit #(
        .ADDR_WIDTH   (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0180),
        .RAS_DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        b.branch_taken  = 1'b0;
        b.branch_offset = '0;
        b.jump          = 1'b0;
        b.jump_index    = '0;
        b.jump_reg      = 1'b0;
        b.jr_target     = '0;
        b.link          = 1'b0;
        b.ret           = 1'b0;
        b.exception     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b.en = 1'b0;
        clear();
        #2;
        check("rst_pc", b.pc, 32'h0);
        check("rst_pc_plus4", b.pc_plus4, 32'h4);
        check("rst_ras_top", b.ras_top, 32'h0);
        check("rst_ras_valid", {31'b0, b.ras_valid}, 32'h0);
        check("rst_overflow", {31'b0, b.ras_overflow}, 32'h0);
        check("rst_misaligned", {31'b0, b.misaligned}, 32'h0);

        @(negedge clk);
        rst  = 1'b0;
        b.en = 1'b1;
        #1;
        check("seq0", b.pc, 32'h0);
        step(); check("seq1", b.pc, 32'h4);
        step(); check("seq2", b.pc, 32'h8);
        step(); check("seq3", b.pc, 32'hC);

        clear(); b.jump = 1'b1; b.jump_index = 26'h40;
        step(); check("j_0x100", b.pc, 32'h100);
        clear(); b.branch_taken = 1'b1; b.branch_offset = 32'hFFFF_FFFE;
        step(); check("br_back", b.pc, 32'hFC);
        b.jump = 1'b1; b.jump_index = 26'h40;
        step(); check("j_over_br", b.pc, 32'h100);
        clear(); b.jump = 1'b1; b.jump_index = 26'h4;
        step(); check("j_0x10", b.pc, 32'h10);

        for (int i = 1; i <= 5; i++) begin
            clear(); b.jump = 1'b1; b.link = 1'b1;
            b.jump_index = 26'((32'h10 * (i + 1)) >> 2);
            step();
            check("jal_pc", b.pc, 32'h10 * (i + 1));
            check("jal_top", b.ras_top, 32'h10 * i + 32'h4);
            check("jal_valid", {31'b0, b.ras_valid}, 32'h1);
            check("jal_overflow", {31'b0, b.ras_overflow}, (i == 5) ? 32'h1 : 32'h0);
        end

        for (int k = 0; k < 4; k++) begin
            clear(); b.jump_reg = 1'b1; b.ret = 1'b1; b.jr_target = 32'h200;
            step();
            check("pop_pc", b.pc, 32'h200);
            check("pop_top", b.ras_top, (k == 0) ? 32'h44 : (k == 1) ? 32'h34 : (k == 2) ? 32'h24 : 32'h0);
            check("pop_valid", {31'b0, b.ras_valid}, (k < 3) ? 32'h1 : 32'h0);
        end
        check("overflow_sticky", {31'b0, b.ras_overflow}, 32'h1);

        clear(); b.jump = 1'b1; b.link = 1'b1; b.jump_index = 26'hC0;
        step(); check("jal_0x300", b.pc, 32'h300); check("push_top", b.ras_top, 32'h204);
        clear(); b.jump_reg = 1'b1; b.link = 1'b1; b.ret = 1'b1; b.jr_target = 32'h400;
        step();
        check("jalr_pc", b.pc, 32'h400);
        check("replace_top", b.ras_top, 32'h304);
        check("replace_valid", {31'b0, b.ras_valid}, 32'h1);

        clear(); b.jump_reg = 1'b1; b.link = 1'b1; b.ret = 1'b1; b.jr_target = 32'h202;
        #1; check("misaligned_flag", {31'b0, b.misaligned}, 32'h1);
        step();
        check("misaligned_pc", b.pc, 32'h180);
        check("misaligned_ras_top", b.ras_top, 32'h304);
        check("misaligned_ras_valid", {31'b0, b.ras_valid}, 32'h1);
        clear();
        step(); check("seq_0x184", b.pc, 32'h184);
        clear(); b.exception = 1'b1; b.jump_reg = 1'b1; b.link = 1'b1; b.ret = 1'b1; b.jr_target = 32'h202;
        #1; check("exc_masks_misaligned", {31'b0, b.misaligned}, 32'h0);
        step();
        check("exc_pc", b.pc, 32'h180);
        check("exc_ras_top", b.ras_top, 32'h304);

        clear();
        step(); check("seq_0x184b", b.pc, 32'h184);
        b.en = 1'b0; b.branch_taken = 1'b1; b.branch_offset = 32'h10;
        for (int s = 0; s < 3; s++) begin
            step(); check("stall_hold", b.pc, 32'h184);
        end
        b.exception = 1'b1;
        step(); check("stall_exc", b.pc, 32'h180);

        clear(); b.en = 1'b1; b.jump = 1'b1; b.link = 1'b1; b.jump_index = 26'h10;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", b.pc, 32'h0);
        check("async_rst_valid", {31'b0, b.ras_valid}, 32'h0);
        check("async_rst_top", b.ras_top, 32'h0);
        check("async_rst_overflow", {31'b0, b.ras_overflow}, 32'h0);
        check("async_rst_pc_plus4", b.pc_plus4, 32'h4);
        step();
        check("rst_held_pc", b.pc, 32'h0);
        check("rst_held_valid", {31'b0, b.ras_valid}, 32'h0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter stage for the single-cycle MIPS core. It holds the PC register and selects the next PC by priority from sequential, branch, jump, jump-register and exception sources. It adds a stall enable, misaligned-target trapping and a small return-address stack (RAS) that gives the fetch stage a predicted `jr $ra` target. It sits between the control/branch logic and the instruction memory address port, and supersedes the two-input jump select.

## Interface
- `ADDR_WIDTH`, 32, PC width; must be ≥ 28.
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded by reset.
- `EXC_VECTOR`, 32'h0000_0180, PC value loaded on exception or misaligned target.
- `RAS_DEPTH`, 4, number of return-address entries; power of two, ≥ 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; low = stall (PC and RAS hold).
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_offset`  in  ADDR_WIDTH  sign-extended word offset (imm16, extended).
- `jump`  in  1  J/JAL instruction.
- `jump_index`  in  26  instr[25:0].
- `jump_reg`  in  1  JR/JALR instruction.
- `jr_target`  in  ADDR_WIDTH  register-file value for JR.
- `link`  in  1  JAL/JALR: push return address.
- `ret`  in  1  JR with rs = $ra: pop the RAS.
- `exception`  in  1  trap request.
- `pc`  out  ADDR_WIDTH  current PC (registered).
- `pc_plus4`  out  ADDR_WIDTH  pc + 4 (combinational).
- `ras_top`  out  ADDR_WIDTH  predicted return address; 0 when empty.
- `ras_valid`  out  1  RAS non-empty.
- `ras_overflow`  out  1  sticky; set when a push discards the oldest entry.
- `misaligned`  out  1  selected JR target has bits[1:0] ≠ 0 (combinational).

## Operation
- Candidate targets, all modulo 2^ADDR_WIDTH:
  - seq = pc + 4
  - br = pc_plus4 + (branch_offset << 2)
  - j = {pc_plus4[ADDR_WIDTH-1:28], jump_index, 2'b00}
  - jr = jr_target
- Selection priority: `exception` > `jump_reg` > `jump` > `branch_taken` > seq.
- Misaligned trap: if `jump_reg` is selected and jr_target[1:0] ≠ 0, `misaligned`=1 and next PC = EXC_VECTOR. `misaligned` is 0 whenever `exception` is high.
- PC update:
  - `exception` loads EXC_VECTOR regardless of `en`.
  - Otherwise PC loads the selected target only when `en`=1 and holds when `en`=0.
- RAS is a circular buffer with a write pointer and an occupancy count 0..RAS_DEPTH. It updates only when `en`=1, `exception`=0 and there is no misaligned trap.
  - push (`link`): store pc_plus4 at the pointer, advance the pointer, count += 1.
  - Push when full: overwrite the oldest entry, count stays at RAS_DEPTH, set `ras_overflow`.
  - pop (`jump_reg & ret`): retreat the pointer, count −= 1. Pop when empty is ignored.
  - Push and pop in the same cycle: the top entry is replaced with pc_plus4; pointer and count are unchanged. If the RAS is empty this is a plain push.
  - `link` and `ret` are ignored unless `jump` or `jump_reg` is high.
- `ras_top` = entry at pointer−1 when count > 0, else 0. `ras_valid` = (count ≠ 0).

## Timing
- Reset (asynchronous assert): pc = RESET_VECTOR, pointer = 0, count = 0, `ras_overflow` = 0, all RAS entries = 0. `pc_plus4` = RESET_VECTOR+4, `ras_top` = 0, `ras_valid` = 0, `misaligned` = 0.
- Reset deassertion is synchronised externally. The first PC update occurs on the first rising edge with `rst` low.
- Latency: the selected target appears on `pc` one cycle after the control inputs. The RAS reflects a push or pop on the same edge.
- Reset asserted mid-stall or mid-push: the reset values win immediately; no partial update.
- `pc_plus4` and `misaligned` are pure combinational functions of `pc` and the current-cycle inputs. There is no input-to-`pc` combinational path.

## Structure
- Package `pc_pkg` holds:
  - next-PC select enum `pc_sel_e` {PC_SEQ, PC_BR, PC_J, PC_JR, PC_EXC};
  - constant `PC_INCR` = 4;
  - default vector constants.
- Sub-module `return_addr_stack`, parametrised by ADDR_WIDTH and RAS_DEPTH, with ports push, pop, din, top, valid, overflow.
- The top level contains the priority select, misaligned check and PC register.

## Test plan
- Reset, then 3 cycles with en=1 and no control inputs -> pc 0x0, 0x4, 0x8, 0xC.
- pc=0x100, branch_taken=1, branch_offset=0xFFFF_FFFE -> pc=0xFC. Same cycle with jump=1, jump_index=0x40 -> pc=0x100 (jump wins).
- Sequence JAL at 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4) -> ras_top 0x14, 0x24, 0x34, 0x44, 0x54; ras_overflow=1 after the 5th push; four pops -> tops 0x44, 0x34, 0x24, then ras_valid=0.
- jump_reg=1, jr_target=0x202 -> misaligned=1, pc=0x180, RAS unchanged. Repeat with exception=1 -> misaligned=0, pc=0x180.
- en=0 for 3 cycles with branch_taken=1 -> pc holds. exception=1 while en=0 -> pc=0x180 next edge.
- Assert rst asynchronously between edges during a JAL push -> pc=0 and ras_valid=0 immediately.
